lsu_mem_req: RTL
================

// Module: lsu_mem_req
// PURPOSE
//  Load/store request engine: the initiator side of the data-memory port.
//  Takes one load/store op at a time from the MEM stage and issues a word-aligned
//  request with byte enables and lane-replicated write data. Waits for grant and
//  load response, extracts and extends load data, returns one result per op.
//  Flags misaligned accesses and response timeouts instead of touching memory.
// PARAMETERS
//  TIMEOUT   16   max cycles in WAIT for mem_rvalid before a bus-error result (>=1)
// PORTS
//  clk          in   1   single clock, all state on posedge
//  reset        in   1   asynchronous, active-high; returns block to IDLE
//  op_valid     in   1   op presented by pipeline
//  op_ready     out  1   block can accept an op (high only in IDLE)
//  op_type      in   3   000 lw,001 lh,010 lhu,011 lb,100 lbu,101 sw,110 sh,111 sb
//  op_addr      in   32  byte address
//  op_wdata     in   32  store data (low bits used for sh/sb)
//  op_pc        in   32  PC of op, echoed on result
//  mem_req      out  1   request valid; held stable until mem_gnt
//  mem_gnt      in   1   memory accepts request this cycle
//  mem_we       out  1   1 = store
//  mem_addr     out  32  {op_addr[31:2],2'b00}
//  mem_be       out  4   byte enables, bit i = byte lane i
//  mem_wdata    out  32  lane-replicated store data
//  mem_rvalid   in   1   load data valid
//  mem_rdata    in   32  load word
//  res_valid    out  1   one-cycle pulse: op complete
//  res_data     out  32  extended load data; 0 for stores and errors
//  res_exc      out  2   00 ok, 01 misaligned, 10 timeout
//  res_pc       out  32  latched op_pc
// BEHAVIOUR
//  - Reset (async): state=IDLE, all outputs 0 except op_ready=1; timeout counter 0.
//  - FSM IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
//  - IDLE: op_ready=1. op_valid&op_ready latches type/addr/wdata/pc.
//    Misaligned (lw/sw addr[1:0]!=0; lh/lhu/sh addr[0]!=0) -> DONE, res_exc=01,
//    mem_req never asserted. Otherwise -> REQ.
//  - REQ: mem_req=1 with stable addr/we/be/wdata. On mem_gnt: store -> DONE;
//    load -> WAIT, counter cleared. Grant may come in the first REQ cycle.
//  - WAIT: mem_req=0. mem_rvalid -> capture extracted data, -> DONE.
//    Counter increments each WAIT cycle without rvalid; reaching TIMEOUT -> DONE,
//    res_exc=10, res_data=0. rvalid on the TIMEOUT cycle wins (ok result).
//  - DONE: res_valid=1 for exactly one cycle, res_* registered; -> IDLE.
//    Minimum latency op accept -> res_valid: store 2 cycles, load 3 cycles.
//  - mem_rvalid / mem_gnt outside WAIT / REQ are ignored.
//  - Byte enables: word 1111; half addr[1]=0 -> 0011, 1 -> 1100;
//    byte -> 1<<addr[1:0]. Loads drive the same be pattern, mem_we=0.
//  - Write data: sw as-is; sh {2{wdata[15:0]}}; sb {4{wdata[7:0]}}.
//  - Load extract: half = rdata[16*addr[1] +:16], byte = rdata[8*addr[1:0] +:8];
//    lh/lb sign-extend, lhu/lbu zero-extend, lw passthrough.
//  - Reset mid-operation aborts op: no res_valid, mem_req drops immediately.
// TESTING
//  1 sw addr 0x3004 data 0x12345678, gnt 2 cycles late -> mem_be 1111,
//    mem_addr 0x3004, mem_req held 2 cycles, res_valid next cycle, exc 00.
//  2 sb addr 0x3003 data 0x000000AB -> mem_be 1000, mem_wdata 0xABABABAB;
//    sh addr 0x3002 data 0xBEEF -> be 1100, wdata 0xBEEFBEEF.
//  3 lb addr 0x1, rdata 0x00008000 -> res_data 0xFFFFFF80; lbu -> 0x00000080;
//    lh addr 0x2, rdata 0x80010000 -> 0xFFFF8001; lhu -> 0x00008001.
//  4 lw addr 0x2 -> no mem_req, res_valid 1 cycle after accept, exc 01, data 0;
//    lh addr 0x1 -> exc 01.
//  5 lw granted, rvalid withheld -> res_valid after TIMEOUT=16 WAIT cycles,
//    exc 10; late rvalid afterwards ignored, op_ready=1.
//  6 reset pulsed during WAIT -> mem_req/res_valid 0 at once, op_ready 1;
//    next op completes normally.

Source files
------------

// File: rtl/lsu_mem_req.sv
// Load/store request engine: issues one word-aligned memory request per op,
// waits for grant and load data, and returns one extended result per op.
module lsu_mem_req #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [31:0] op_pc,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [1:0]  res_exc,
  output logic [31:0] res_pc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int         CW     = $clog2(TIMEOUT + 1);

  localparam logic [1:0] EXC_OK    = 2'b00;
  localparam logic [1:0] EXC_ALIGN = 2'b01;
  localparam logic [1:0] EXC_TMO   = 2'b10;

  logic [1:0]    state;
  logic [2:0]    typ;
  logic [1:0]    addr_lo;
  logic [CW-1:0] cnt;

  function automatic logic is_store(input logic [2:0] t);
    return t[2] & (t[1] | t[0]);
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    case (t)
      3'b000, 3'b101:         return a != 2'b00;
      3'b001, 3'b010, 3'b110: return a[0];
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] t, input logic [1:0] a);
    case (t)
      3'b000, 3'b101:         return 4'b1111;
      3'b001, 3'b010, 3'b110: return a[1] ? 4'b1100 : 4'b0011;
      default:                return 4'b0001 << a;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] t, input logic [31:0] d);
    case (t)
      3'b101:  return d;
      3'b110:  return {2{d[15:0]}};
      3'b111:  return {4{d[7:0]}};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Pick the addressed lane out of the returned word and extend it.
  function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] a,
                                          input logic [31:0] rd);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? rd[31:16] : rd[15:0];
    b = rd[8*a +: 8];
    case (t)
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {16'h0000, h};
      3'b011:  return {{24{b[7]}}, b};
      3'b100:  return {24'h00_0000, b};
      default: return rd;
    endcase
  endfunction

  // Request FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      typ       <= 3'b000;
      addr_lo   <= 2'b00;
      cnt       <= '0;
      op_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0000_0000;
      res_valid <= 1'b0;
      res_data  <= 32'h0000_0000;
      res_exc   <= 2'b00;
      res_pc    <= 32'h0000_0000;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            typ       <= op_type;
            addr_lo   <= op_addr[1:0];
            res_pc    <= op_pc;
            op_ready  <= 1'b0;
            mem_we    <= is_store(op_type);
            mem_addr  <= {op_addr[31:2], 2'b00};
            mem_be    <= be_of(op_type, op_addr[1:0]);
            mem_wdata <= wdata_of(op_type, op_wdata);
            if (misaligned(op_type, op_addr[1:0])) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_exc   <= EXC_ALIGN;
              res_data  <= 32'h0000_0000;
            end else begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (is_store(typ)) begin
              state     <= S_DONE;
              res_valid <= 1'b1;
              res_exc   <= EXC_OK;
              res_data  <= 32'h0000_0000;
            end else begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
        end
        S_WAIT: begin
          // A response arriving on the last allowed cycle still wins over timeout.
          if (mem_rvalid) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_exc   <= EXC_OK;
            res_data  <= extract(typ, addr_lo, mem_rdata);
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            res_exc   <= EXC_TMO;
            res_data  <= 32'h0000_0000;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
          mem_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
